// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: defaults, FSM encoding
// and the write-port priority helper.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int MAX_WR     = 8;

  localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Highest set index in a write-port hit vector (0 when empty).
  function automatic int unsigned top_hit(input logic [MAX_WR-1:0] hits);
    top_hit = 0;
    for (int unsigned j = 0; j < MAX_WR; j++)
      if (hits[j]) top_hit = j;
  endfunction

endpackage

// File: rtl/regfile_busy_table.sv
// Pending-write scoreboard: one busy bit per register, set by issue and
// cleared by writeback, with per-read-port busy lookup.
module regfile_busy_table
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic                     bset,
  input  logic [ADDR_W-1:0]        bset_addr,
  input  logic [(2**ADDR_W)-1:0]   wclr,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  input  logic [NUM_RD-1:0]        rhit,
  output logic [NUM_RD-1:0]        rbusy
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] bits, bits_nx;

  // Set applied after clear so a newly issued producer survives its
  // predecessor's writeback in the same cycle.
  always_comb begin
    bits_nx = bits;
    if (run) begin
      bits_nx = bits & ~wclr;
      if (bset) bits_nx[bset_addr] = 1'b1;
    end
    bits_nx[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bits <= '0;
    else      bits <= bits_nx;
  end

  always_comb begin
    rbusy = '0;
    for (int unsigned i = 0; i < NUM_RD; i++)
      rbusy[i] = run && re[i] && bits[raddr[i*ADDR_W +: ADDR_W]]
                 && !((BYPASS != 0) && rhit[i]);
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with post-reset zeroing sweep,
// write-to-read bypass and a pending-write busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     init_done,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic                     bset,
  input  logic [ADDR_W-1:0]        bset_addr
);

  localparam int DEPTH = 2**ADDR_W;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   cnt;
  logic [DATA_W-1:0]   regs [DEPTH];
  logic                run;
  logic [DEPTH-1:0]    wclr;
  logic [NUM_RD-1:0]   rhit;
  logic [MAX_WR-1:0]   hits;

  assign run       = (state == ST_RUN);
  assign init_done = run;

  always_comb begin
    state_nx = state;
    if (state == ST_INIT && cnt == ADDR_W'(DEPTH-1)) state_nx = ST_RUN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_INIT) cnt <= cnt + 1'b1;
    end
  end

  // Later ports overwrite earlier ones in loop order, giving highest-index priority.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      regs[cnt] <= DATA_W'(ZERO_WORD);
    end else begin
      for (int unsigned j = 0; j < NUM_WR; j++)
        if (we[j] && waddr[j*ADDR_W +: ADDR_W] != '0)
          regs[waddr[j*ADDR_W +: ADDR_W]] <= wdata[j*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    wclr = '0;
    if (run)
      for (int unsigned j = 0; j < NUM_WR; j++)
        if (we[j]) wclr[waddr[j*ADDR_W +: ADDR_W]] = 1'b1;
  end

  always_comb begin
    rdata = '0;
    rhit  = '0;
    hits  = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      hits = '0;
      for (int unsigned j = 0; j < NUM_WR; j++)
        if (run && we[j] && waddr[j*ADDR_W +: ADDR_W] == raddr[i*ADDR_W +: ADDR_W])
          hits[j] = 1'b1;
      rhit[i] = |hits;
      if (run && re[i] && raddr[i*ADDR_W +: ADDR_W] != '0) begin
        if (BYPASS != 0 && rhit[i])
          rdata[i*DATA_W +: DATA_W] = wdata[top_hit(hits)*DATA_W +: DATA_W];
        else
          rdata[i*DATA_W +: DATA_W] = regs[raddr[i*ADDR_W +: ADDR_W]];
      end
    end
  end

  regfile_busy_table #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .BYPASS (BYPASS)
  ) u_busy (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .bset      (bset),
    .bset_addr (bset_addr),
    .wclr      (wclr),
    .re        (re),
    .raddr     (raddr),
    .rhit      (rhit),
    .rbusy     (rbusy)
  );

endmodule
